// File: rtl/propuesta_cero_axil_pkg.sv
// Shared types and constants for the PropuestaCero AXI4-Lite register bank.
// Contents: AXI4-Lite response encoding, write/read FSM state encodings,
// bus data width.
package propuesta_cero_axil_pkg;

    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/propuesta_cero_axil_regs_if.sv
// AXI4-Lite bus bundle for the PropuestaCero control interface.
// Parameter: ADDR_W - byte-address width.
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// Modports: master (processor / VIP side), slave (register bank side).
interface propuesta_cero_axil_regs_if #(
    parameter int unsigned ADDR_W = 4
);
    import propuesta_cero_axil_pkg::*;

    logic [ADDR_W-1:0]      awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;

    logic [AXIL_DATA_W-1:0] wdata;
    logic [AXIL_STRB_W-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;

    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    logic [ADDR_W-1:0]      araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;

    logic [AXIL_DATA_W-1:0] rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface

// File: rtl/propuesta_cero_axil_strb_merge.sv
// Byte-strobe merge: each byte of the result comes from new_word_i where its
// strobe bit is set, otherwise from old_word_i.
// Ports: old_word_i (current register value), new_word_i (write data),
//        strb_i (byte enables), merged_o (value to store).
module propuesta_cero_axil_strb_merge
    import propuesta_cero_axil_pkg::*;
(
    input  logic [AXIL_DATA_W-1:0] old_word_i,
    input  logic [AXIL_DATA_W-1:0] new_word_i,
    input  logic [AXIL_STRB_W-1:0] strb_i,
    output logic [AXIL_DATA_W-1:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int unsigned b = 0; b < AXIL_STRB_W; b++) begin
            if (strb_i[b]) begin
                merged_o[8*b +: 8] = new_word_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/propuesta_cero_axil_regs.sv
// PropuestaCero AXI4-Lite slave register bank: NUM_REGS x 32-bit registers
// written/read over single-beat AXI4-Lite, contents exported to the datapath.
// Ports:
//   s00_axi_aclk   - clock, rising edge
//   s00_axi_areset - synchronous active-high reset
//   s00_axi        - AXI4-Lite slave bus (propuesta_cero_axil_regs_if.slave)
//   reg_q          - flattened registers, register k at [32k+31:32k]
//   reg_wr_pulse   - one-cycle pulse per register, the cycle after a write
// Build option: define PROPUESTA_CERO_AXIL_SLVERR_EN to answer out-of-range
// accesses with SLVERR; otherwise they answer OKAY (writes dropped, reads 0).
module propuesta_cero_axil_regs
    import propuesta_cero_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                 s00_axi_aclk,
    input  logic                                 s00_axi_areset,
    propuesta_cero_axil_regs_if.slave            s00_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                  reg_wr_pulse
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned DW    = AXIL_DATA_W;

    typedef logic [IDX_W-1:0] idx_t;

`ifdef PROPUESTA_CERO_AXIL_SLVERR_EN
    localparam axil_resp_t OOR_RESP = SLVERR;
`else
    localparam axil_resp_t OOR_RESP = OKAY;
`endif

    // Extra leading zero keeps the compare valid when NUM_REGS == 2**IDX_W.
    function automatic logic in_range(input idx_t idx);
        return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    endfunction

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0][DW-1:0] regs_q;
    logic [NUM_REGS-1:0][DW-1:0] merged;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t              wr_state_q, wr_state_d;
    logic                   aw_held_q;
    idx_t                   aw_idx_q;
    logic                   w_held_q;
    logic [DW-1:0]          wdata_q;
    logic [AXIL_STRB_W-1:0] wstrb_q;
    axil_resp_t             bresp_q;
    logic [NUM_REGS-1:0]    wr_pulse_q;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   wr_commit;
    idx_t                   wr_idx;
    logic [DW-1:0]          wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;
    logic                   wr_ok;

    // A channel arriving on the commit edge is used directly instead of
    // passing through its holding register, so the commit lands on the
    // edge of the second handshake.
    always_comb begin
        aw_hs     = (wr_state_q == W_IDLE) && s00_axi.awvalid && !aw_held_q;
        w_hs      = (wr_state_q == W_IDLE) && s00_axi.wvalid  && !w_held_q;
        wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        wr_idx    = aw_held_q ? aw_idx_q : s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        wr_data   = w_held_q  ? wdata_q  : s00_axi.wdata;
        wr_strb   = w_held_q  ? wstrb_q  : s00_axi.wstrb;
        wr_ok     = in_range(wr_idx);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE:  if (wr_commit)      wr_state_d = W_RESP;
            W_RESP:  if (s00_axi.bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state_q <= W_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= wr_ok ? OKAY : OOR_RESP;
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                    if (wr_ok && (wr_idx == idx_t'(k))) begin
                        wr_pulse_q[k] <= 1'b1;
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s00_axi.wdata;
                    wstrb_q  <= s00_axi.wstrb;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_merge
        propuesta_cero_axil_strb_merge u_merge (
            .old_word_i (regs_q[k]),
            .new_word_i (wr_data),
            .strb_i     (wr_strb),
            .merged_o   (merged[k])
        );
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            regs_q <= '0;
        end else if (wr_commit && wr_ok) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_idx == idx_t'(k)) begin
                    regs_q[k] <= merged[k];
                end
            end
        end
    end

    assign s00_axi.awready = (wr_state_q == W_IDLE) && !aw_held_q;
    assign s00_axi.wready  = (wr_state_q == W_IDLE) && !w_held_q;
    assign s00_axi.bvalid  = (wr_state_q == W_RESP);
    assign s00_axi.bresp   = bresp_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t     rd_state_q, rd_state_d;
    logic [DW-1:0] rdata_q;
    axil_resp_t    rresp_q;
    logic          ar_hs;
    idx_t          rd_idx;
    logic [DW-1:0] rd_word;

    // rd_word samples regs_q before any same-edge write lands, so a
    // colliding read returns the pre-write value.
    always_comb begin
        ar_hs   = (rd_state_q == R_IDLE) && s00_axi.arvalid;
        rd_idx  = s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == idx_t'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs)          rd_state_d = R_DATA;
            R_DATA:  if (s00_axi.rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= in_range(rd_idx) ? OKAY : OOR_RESP;
        end
    end

    assign s00_axi.arready = (rd_state_q == R_IDLE);
    assign s00_axi.rvalid  = (rd_state_q == R_DATA);
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    // ------------------------------------------------------------------
    // Exports
    // ------------------------------------------------------------------
    assign reg_q        = regs_q;
    assign reg_wr_pulse = wr_pulse_q;

    logic unused_bits;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

endmodule

// File: tb/tb_propuesta_cero_axil_regs.sv
// Directed self-checking bench for propuesta_cero_axil_regs (NUM_REGS=4,
// 5-bit address so that 0x10 is out of range). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_propuesta_cero_axil_regs;

    localparam int unsigned AW = 5;
    localparam int unsigned NR = 4;

`ifdef PROPUESTA_CERO_AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic             clk;
    logic             rst;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]    reg_wr_pulse;

    int checks = 0;
    int errors = 0;

    propuesta_cero_axil_regs_if #(.ADDR_W(AW)) axi ();

    propuesta_cero_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (axi),
        .reg_q          (reg_q),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the B handshake done.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
        int n;
        axi.awaddr  = a;
        axi.awvalid = 1'b1;
        axi.wdata   = d;
        axi.wstrb   = s;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b0;
        n = 0;
        while (!(axi.awready && axi.wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_accept", 128'(axi.awready && axi.wready), 128'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("wr_bvalid_latency", 128'(axi.bvalid), 128'd1);
        resp  = axi.bresp;
        pulse = reg_wr_pulse;
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("wr_bvalid_clear", 128'(axi.bvalid), 128'd0);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        axi.araddr  = a;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        n = 0;
        while (!axi.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_accept", 128'(axi.arready), 128'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("rd_rvalid_latency", 128'(axi.rvalid), 128'd1);
        d    = axi.rdata;
        resp = axi.rresp;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("rd_rvalid_clear", 128'(axi.rvalid), 128'd0);
    endtask

    initial begin
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
        logic [31:0]   rd;
        logic [31:0]   wvals [4];
        logic [NR-1:0] pulses [4];
        logic [127:0]  exp_regs;

        wvals[0] = 32'h1;  wvals[1] = 32'h2;  wvals[2] = 32'h3;  wvals[3] = 32'h4;
        pulses[0] = 4'b0001; pulses[1] = 4'b0010; pulses[2] = 4'b0100; pulses[3] = 4'b1000;

        rst = 1'b1;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata  = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
        axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_awready", 128'(axi.awready), 128'd1);
        check("rst_wready",  128'(axi.wready),  128'd1);
        check("rst_arready", 128'(axi.arready), 128'd1);
        check("rst_bvalid",  128'(axi.bvalid),  128'd0);
        check("rst_rvalid",  128'(axi.rvalid),  128'd0);
        check("rst_bresp",   128'(axi.bresp),   128'd0);
        check("rst_rresp",   128'(axi.rresp),   128'd0);
        check("rst_rdata",   128'(axi.rdata),   128'd0);
        check("rst_reg_q",   reg_q,             128'd0);
        check("rst_pulse",   128'(reg_wr_pulse), 128'd0);

        // Sequential writes then reads
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4*i), wvals[i], 4'hF, resp, pulse);
            check("seq_bresp", 128'(resp), 128'd0);
            check("seq_pulse", 128'(pulse), 128'(pulses[i]));
        end
        check("seq_reg_q", reg_q, 128'h00000004_00000003_00000002_00000001);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4*i), rd, resp);
            check("seq_rdata", 128'(rd), 128'(wvals[i]));
            check("seq_rresp", 128'(resp), 128'd0);
        end

        // Partial strobe onto register 1 (holds 0x2)
        axi_write(5'h04, 32'hAABBCCDD, 4'b0101, resp, pulse);
        check("strb_bresp", 128'(resp), 128'd0);
        check("strb_pulse", 128'(pulse), 128'b0010);
        axi_read(5'h04, rd, resp);
        check("strb_rdata", 128'(rd), 128'h00BB00DD);

        // W three cycles ahead of AW, into register 2 (holds 0x3)
        axi.wdata = 32'h11223344; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.wvalid = 1'b0;
        check("wfirst_wready_held", 128'(axi.wready), 128'd0);
        for (int i = 0; i < 2; i++) begin
            check("wfirst_no_bvalid", 128'(axi.bvalid), 128'd0);
            check("wfirst_reg_hold", 128'(reg_q[95:64]), 128'h3);
            @(negedge clk);
        end
        axi.awaddr = 5'h08; axi.awvalid = 1'b1;
        check("wfirst_pre_bvalid", 128'(axi.bvalid), 128'd0);
        check("wfirst_pre_reg", 128'(reg_q[95:64]), 128'h3);
        @(negedge clk);
        axi.awvalid = 1'b0;
        check("wfirst_bvalid", 128'(axi.bvalid), 128'd1);
        check("wfirst_reg", 128'(reg_q[95:64]), 128'h11223344);
        check("wfirst_pulse", 128'(reg_wr_pulse), 128'b0100);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("wfirst_bclear", 128'(axi.bvalid), 128'd0);

        // AW two cycles ahead of W, into register 3 (holds 0x4)
        axi.awaddr = 5'h0C; axi.awvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        check("awfirst_awready_held", 128'(axi.awready), 128'd0);
        check("awfirst_wready", 128'(axi.wready), 128'd1);
        @(negedge clk);
        check("awfirst_no_bvalid", 128'(axi.bvalid), 128'd0);
        check("awfirst_reg_hold", 128'(reg_q[127:96]), 128'h4);
        axi.wdata = 32'h55667788; axi.wstrb = 4'b0011; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.wvalid = 1'b0;
        check("awfirst_bvalid", 128'(axi.bvalid), 128'd1);
        check("awfirst_reg", 128'(reg_q[127:96]), 128'h00007788);
        check("awfirst_pulse", 128'(reg_wr_pulse), 128'b1000);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;

        // Out-of-range write and read
        exp_regs = 128'h00007788_11223344_00BB00DD_00000001;
        check("pre_oor_regs", reg_q, exp_regs);
        axi_write(5'h10, 32'hDEADBEEF, 4'hF, resp, pulse);
        check("oor_bresp", 128'(resp), 128'(OOR_RESP));
        check("oor_pulse", 128'(pulse), 128'd0);
        check("oor_regs", reg_q, exp_regs);
        axi_read(5'h10, rd, resp);
        check("oor_rdata", 128'(rd), 128'd0);
        check("oor_rresp", 128'(resp), 128'(OOR_RESP));

        // B back-pressure: bvalid holds, a new AW is refused
        axi.awaddr = 5'h00; axi.wdata = 32'hCAFEF00D; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        @(negedge clk);
        axi.wvalid = 1'b0;
        axi.awaddr = 5'h04;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", 128'(axi.bvalid), 128'd1);
            check("bp_bresp", 128'(axi.bresp), 128'd0);
            check("bp_awready", 128'(axi.awready), 128'd0);
            @(negedge clk);
        end
        axi.awvalid = 1'b0;
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("bp_bclear", 128'(axi.bvalid), 128'd0);
        check("bp_reg0", 128'(reg_q[31:0]), 128'hCAFEF00D);
        check("bp_reg1", 128'(reg_q[63:32]), 128'h00BB00DD);

        // R back-pressure: rvalid/rdata hold, a new AR is refused
        axi.araddr = 5'h08; axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(negedge clk);
        axi.araddr = 5'h0C;
        for (int i = 0; i < 5; i++) begin
            check("rp_rvalid", 128'(axi.rvalid), 128'd1);
            check("rp_rdata", 128'(axi.rdata), 128'h11223344);
            check("rp_arready", 128'(axi.arready), 128'd0);
            @(negedge clk);
        end
        axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        @(negedge clk);
        axi.rready = 1'b0;
        check("rp_rclear", 128'(axi.rvalid), 128'd0);

        // Reset while bvalid and rvalid are pending
        axi.awaddr = 5'h04; axi.wdata = 32'h77; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 5'h00; axi.arvalid = 1'b1;
        @(negedge clk);
        axi.arvalid = 1'b0;
        check("mid_bvalid_before", 128'(axi.bvalid), 128'd1);
        check("mid_rvalid_before", 128'(axi.rvalid), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_bvalid_rst", 128'(axi.bvalid), 128'd0);
        check("mid_rvalid_rst", 128'(axi.rvalid), 128'd0);
        check("mid_regs_rst", reg_q, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset while AW is held: the held address must be discarded
        axi.awaddr = 5'h04; axi.awvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        check("held_aw", 128'(axi.awready), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("held_aw_cleared", 128'(axi.awready), 128'd1);
        axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(negedge clk);
        axi.wvalid = 1'b0;
        check("post_rst_w_only_bvalid", 128'(axi.bvalid), 128'd0);
        check("post_rst_w_only_regs", reg_q, 128'd0);
        axi.awaddr = 5'h00; axi.awvalid = 1'b1;
        @(negedge clk);
        axi.awvalid = 1'b0;
        check("post_rst_bvalid", 128'(axi.bvalid), 128'd1);
        check("post_rst_bresp", 128'(axi.bresp), 128'd0);
        check("post_rst_pulse", 128'(reg_wr_pulse), 128'b0001);
        check("post_rst_regs", reg_q, 128'h5);
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("post_rst_bclear", 128'(axi.bvalid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
